// File: rtl/mem_loader.sv
// Byte-stream loader: length-prefixed byte pairs are packed into 16-bit words and
// written to consecutive addresses while the CPU is held in reset.
module mem_loader #(
  parameter int unsigned                  ADDR_WIDTH = 16,
  parameter logic        [ADDR_WIDTH-1:0] START_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  mem_we,
  output logic                  cpu_hold,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [15:0]             r_idx;
  logic [15:0]             r_n;
  logic [7:0]              r_hi;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [15:0]             r_wdata;

  logic                    w_xfer;
  logic                    w_last;
  logic [ADDR_WIDTH-1:0]   w_addr_next;

  assign w_xfer      = in_valid && in_ready;
  // N is never 0 in WRITE (a zero header goes straight to DONE), so N-1 cannot underflow.
  assign w_last      = (r_idx == (r_n - 16'd1));
  assign w_addr_next = START_ADDR + ADDR_WIDTH'(r_idx);

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    mem_we       = 1'b0;
    done         = 1'b0;
    cpu_hold     = 1'b1;
    unique case (r_state)
      S_HDR_HI: begin
        in_ready = 1'b1;
        if (w_xfer) w_state_next = S_HDR_LO;
      end
      S_HDR_LO: begin
        in_ready = 1'b1;
        if (w_xfer) begin
          if ({r_n[15:8], in_data} == 16'd0) w_state_next = S_DONE;
          else                                w_state_next = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        in_ready = 1'b1;
        if (w_xfer) w_state_next = S_DATA_LO;
      end
      S_DATA_LO: begin
        in_ready = 1'b1;
        if (w_xfer) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        mem_we       = 1'b1;
        w_state_next = w_last ? S_DONE : S_DATA_HI;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) w_state_next = S_HDR_HI;
      end
      default: w_state_next = S_HDR_HI;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_HDR_HI;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx   <= '0;
      r_n     <= '0;
      r_hi    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      unique case (r_state)
        S_HDR_HI:  if (w_xfer) r_n[15:8] <= in_data;
        S_HDR_LO: begin
          if (w_xfer) begin
            r_n[7:0] <= in_data;
            r_idx    <= '0;
          end
        end
        S_DATA_HI: if (w_xfer) r_hi <= in_data;
        S_DATA_LO: begin
          if (w_xfer) begin
            r_wdata <= {r_hi, in_data};
            r_addr  <= w_addr_next;
          end
        end
        S_WRITE:   r_idx <= r_idx + 16'd1;
        default:   ;
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader; a second instance covers address wrap at the top of memory.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  v_data = 8'h00;
  logic        v_valid = 1'b0;
  logic        sel2 = 1'b0;

  logic        in_ready1, in_ready2;
  logic [15:0] mem_addr1, mem_addr2, mem_wdata1, mem_wdata2;
  logic        mem_we1, mem_we2, cpu_hold1, cpu_hold2, done1, done2;
  logic        w_valid1, w_valid2, w_start1, w_start2, w_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] q_addr1[$], q_data1[$], q_addr2[$], q_data2[$];

  assign w_valid1 = v_valid && !sel2;
  assign w_valid2 = v_valid && sel2;
  assign w_start1 = start && !sel2;
  assign w_start2 = start && sel2;
  assign w_ready  = sel2 ? in_ready2 : in_ready1;

  always #5 clk = ~clk;

  mem_loader #(.ADDR_WIDTH(16), .START_ADDR(16'h0000)) dut (
    .clk(clk), .reset(reset), .start(w_start1), .in_data(v_data), .in_valid(w_valid1),
    .in_ready(in_ready1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1),
    .cpu_hold(cpu_hold1), .done(done1)
  );

  mem_loader #(.ADDR_WIDTH(16), .START_ADDR(16'hFFFF)) dut_wrap (
    .clk(clk), .reset(reset), .start(w_start2), .in_data(v_data), .in_valid(w_valid2),
    .in_ready(in_ready2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2),
    .cpu_hold(cpu_hold2), .done(done2)
  );

  always @(negedge clk) begin
    if (mem_we1) begin q_addr1.push_back(mem_addr1); q_data1.push_back(mem_wdata1); end
    if (mem_we2) begin q_addr2.push_back(mem_addr2); q_data2.push_back(mem_wdata2); end
  end

  // Called at a negedge; returns at the negedge following the transfer edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int waited;
    if (gap) begin
      v_valid = 1'b0;
      v_data  = 8'hFF;
      @(negedge clk);
    end
    v_data  = b;
    v_valid = 1'b1;
    waited  = 0;
    while (!w_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (!w_ready) begin
      n_fail++;
      $display("FAIL ready_timeout: byte %h in_ready=%b required 1 within 20 cycles", b, w_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q_addr1.delete(); q_data1.delete(); q_addr2.delete(); q_data2.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset   = 1'b1;
    v_valid = 1'b0;
    #1;
    n_checks++;
    if ({in_ready1, mem_we1, cpu_hold1, done1} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_ctrl: {ready,we,hold,done}=%b required 1010",
               {in_ready1, mem_we1, cpu_hold1, done1});
    end
    n_checks++;
    if (mem_addr1 !== 16'h0000 || mem_wdata1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wdata=%h required 0000/0000", mem_addr1, mem_wdata1);
    end
    @(negedge clk);
    reset = 1'b0;
    q_addr1.delete(); q_data1.delete(); q_addr2.delete(); q_data2.delete();
  endtask

  task automatic test_basic();
    logic [7:0]  bytes [8] = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h0D};
    logic [15:0] exp_d [3] = '{16'h1234, 16'hABCD, 16'h000D};
    do_reset();
    foreach (bytes[i]) send_byte(bytes[i], 1'b0);
    v_valid = 1'b0;
    n_checks++;
    if ({mem_we1, in_ready1, done1, cpu_hold1} !== 4'b1001) begin
      n_fail++;
      $display("FAIL basic_last_write: {we,ready,done,hold}=%b required 1001",
               {mem_we1, in_ready1, done1, cpu_hold1});
    end
    @(negedge clk);
    n_checks++;
    if ({mem_we1, done1, cpu_hold1} !== 3'b010) begin
      n_fail++;
      $display("FAIL basic_done: {we,done,hold}=%b required 010", {mem_we1, done1, cpu_hold1});
    end
    n_checks++;
    if (q_addr1.size() != 3) begin
      n_fail++;
      $display("FAIL basic_count: writes=%0d required 3", q_addr1.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (q_addr1[i] !== 16'(i) || q_data1[i] !== exp_d[i]) begin
          n_fail++;
          $display("FAIL basic_write%0d: addr=%h data=%h required %h/%h",
                   i, q_addr1[i], q_data1[i], 16'(i), exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    n_checks++;
    if (in_ready1 !== 1'b0 || mem_we1 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_write_stall: ready=%b we=%b required 0/1", in_ready1, mem_we1);
    end
    send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
    v_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (q_addr1.size() != 2 || q_data1[1] !== 16'h0304 || q_addr1[1] !== 16'h0001 || done1 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_result: writes=%0d last=%h@%h done=%b required 2 0304@0001 1",
               q_addr1.size(), q_data1[q_data1.size()-1], q_addr1[q_addr1.size()-1], done1);
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    v_valid = 1'b0;
    n_checks++;
    if ({done1, cpu_hold1, in_ready1} !== 3'b100) begin
      n_fail++;
      $display("FAIL zero_done: {done,hold,ready}=%b required 100", {done1, cpu_hold1, in_ready1});
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (q_addr1.size() != 0 || done1 !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_nowrite: writes=%0d done=%b required 0/1", q_addr1.size(), done1);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({cpu_hold1, in_ready1, done1} !== 3'b110) begin
      n_fail++;
      $display("FAIL zero_restart: {hold,ready,done}=%b required 110", {cpu_hold1, in_ready1, done1});
    end
  endtask

  task automatic test_gappy();
    logic [7:0] bytes [6] = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    q_addr1.delete(); q_data1.delete();
    foreach (bytes[i]) send_byte(bytes[i], 1'b1);
    v_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (q_addr1.size() != 2 || done1 !== 1'b1) begin
      n_fail++;
      $display("FAIL gappy_count: writes=%0d done=%b required 2/1", q_addr1.size(), done1);
    end else begin
      n_checks++;
      if (q_addr1[0] !== 16'h0000 || q_data1[0] !== 16'h1122 ||
          q_addr1[1] !== 16'h0001 || q_data1[1] !== 16'h3344) begin
        n_fail++;
        $display("FAIL gappy_data: %h@%h %h@%h required 1122@0000 3344@0001",
                 q_data1[0], q_addr1[0], q_data1[1], q_addr1[1]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] bytes [6] = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset();
    sel2 = 1'b1;
    foreach (bytes[i]) send_byte(bytes[i], 1'b0);
    v_valid = 1'b0;
    repeat (2) @(negedge clk);
    sel2 = 1'b0;
    n_checks++;
    if (q_addr2.size() != 2 || done2 !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_count: writes=%0d done=%b required 2/1", q_addr2.size(), done2);
    end else begin
      n_checks++;
      if (q_addr2[0] !== 16'hFFFF || q_data2[0] !== 16'hAABB ||
          q_addr2[1] !== 16'h0000 || q_data2[1] !== 16'hCCDD) begin
        n_fail++;
        $display("FAIL wrap_data: %h@%h %h@%h required AABB@FFFF CCDD@0000",
                 q_data2[0], q_addr2[0], q_data2[1], q_addr2[1]);
      end
    end
  endtask

  task automatic test_reset_midword();
    do_reset();
    send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h55, 1'b0);
    v_valid = 1'b0;
    reset   = 1'b1;
    #1;
    n_checks++;
    if ({cpu_hold1, in_ready1, done1, mem_we1} !== 4'b1100) begin
      n_fail++;
      $display("FAIL midreset_state: {hold,ready,done,we}=%b required 1100",
               {cpu_hold1, in_ready1, done1, mem_we1});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (q_addr1.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_nowrite: writes=%0d required 0", q_addr1.size());
    end
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h9A, 1'b0); send_byte(8'hBC, 1'b0);
    v_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (q_addr1.size() != 1 || q_addr1[0] !== 16'h0000 || q_data1[0] !== 16'h9ABC || done1 !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_reload: writes=%0d first=%h@%h done=%b required 1 9ABC@0000 1",
               q_addr1.size(), q_data1[0], q_addr1[0], done1);
    end
  endtask

  task automatic test_start_ignored();
    do_reset();
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h77, 1'b0);
    v_valid = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (in_ready1 !== 1'b1 || cpu_hold1 !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ignored_state: ready=%b hold=%b required 1/1", in_ready1, cpu_hold1);
    end
    send_byte(8'h88, 1'b0);
    v_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (q_addr1.size() != 1 || q_data1[0] !== 16'h7788 || q_addr1[0] !== 16'h0000 || done1 !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ignored_write: writes=%0d first=%h@%h done=%b required 1 7788@0000 1",
               q_addr1.size(), q_data1[0], q_addr1[0], done1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset();
    test_back_to_back();
    test_zero_len();
    test_gappy();
    test_wrap();
    test_reset_midword();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
